alu_result_buffer: RTL

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_result_buffer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_result_buffer.sv
// alu_result_buffer
//   Two-entry skid FIFO between the ALU and the memory stage. Each entry
//   holds the ALU result, the store data, the destination register and the
//   control bits. The zero/negative/exception flags are computed when the
//   entry is captured. A trapping overflow cancels every side effect of
//   the instruction.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready depends only on count)
//   in_result, in_store datapath payload (DW bits)
//   in_ovf, in_trap_en  overflow and trap enable for this instruction
//   in_rd               destination register index (RW bits)
//   in_regwrite/in_memread/in_memwrite  control bits carried along
//   flush               synchronous discard of all entries (highest priority)
//   out_valid/out_ready downstream handshake on the head entry
//   out_*               head entry fields, forced to 0 while empty
//   count               number of buffered entries (0..2)
module alu_result_buffer #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_result,
  input  logic          in_ovf,
  input  logic          in_trap_en,
  input  logic [RW-1:0] in_rd,
  input  logic          in_regwrite,
  input  logic          in_memread,
  input  logic          in_memwrite,
  input  logic [DW-1:0] in_store,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [DW-1:0] out_store,
  output logic [RW-1:0] out_rd,
  output logic          out_regwrite,
  output logic          out_memread,
  output logic          out_memwrite,
  output logic          out_zero,
  output logic          out_neg,
  output logic          out_exc,
  output logic [1:0]    count
);

  typedef struct packed {
    logic [DW-1:0] result;
    logic [DW-1:0] store;
    logic [RW-1:0] rd;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          zero;
    logic          neg;
    logic          exc;
  } entry_t;

  // Build a stored entry from the raw ALU outputs. A trapping overflow
  // keeps the payload for the exception handler but kills all writes.
  function automatic entry_t build_entry(
    input logic [DW-1:0] result,
    input logic [DW-1:0] store,
    input logic [RW-1:0] rd,
    input logic          regwrite,
    input logic          memread,
    input logic          memwrite,
    input logic          ovf,
    input logic          trap_en
  );
    entry_t e;
    logic   exc;
    exc        = ovf & trap_en;
    e.result   = result;
    e.store    = store;
    e.rd       = rd;
    e.regwrite = regwrite & ~exc;
    e.memread  = memread & ~exc;
    e.memwrite = memwrite & ~exc;
    e.zero     = (result == {DW{1'b0}});
    e.neg      = result[DW-1];
    e.exc      = exc;
    return e;
  endfunction

  entry_t     mem_r [2];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] count_r;
  logic       wr_s;
  logic       rd_s;
  entry_t     head_s;

  // The handshake depends on registered occupancy only, so out_ready
  // never reaches in_ready combinationally.
  assign in_ready  = (count_r < 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign count     = count_r;

  assign wr_s = in_valid & in_ready & ~flush;
  assign rd_s = out_valid & out_ready & ~flush;

  // Select the head entry. An empty buffer presents all zeros.
  always_comb begin
    head_s = '0;
    if (count_r != 2'd0) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = '0;
    end
  end

  assign out_result   = head_s.result;
  assign out_store    = head_s.store;
  assign out_rd       = head_s.rd;
  assign out_regwrite = head_s.regwrite;
  assign out_memread  = head_s.memread;
  assign out_memwrite = head_s.memwrite;
  assign out_zero     = head_s.zero;
  assign out_neg      = head_s.neg;
  assign out_exc      = head_s.exc;

  // Storage, pointers and occupancy. Flush overrides both write and drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= build_entry(in_result, in_store, in_rd, in_regwrite,
                                       in_memread, in_memwrite, in_ovf, in_trap_en);
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (rd_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
